// File: rtl/collision_pkg.sv
// -----------------------------------------------------------------------------
// collision_pkg
// Purpose : shared constants and types for the collision scan controller and
//           the block-table RAM that feeds it.
//   - screen / block geometry and the derived grid size (COLS, ROWS, N_SLOTS)
//   - AW  : block-table address width
//   - CW/RW : widths of the column / row tracking counters
//   - Y_TOL : landing tolerance, only used when COLLISION_Y_TOLERANCE_EN is set
//   - state_t       : scan controller states
//   - block_entry_t : one block-table word {x, y, active}
// -----------------------------------------------------------------------------
package collision_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int BLOCK_WIDTH   = 64;
  localparam int BLOCK_HEIGHT  = 16;
  localparam int Y_TOL         = 4;

  localparam int COLS    = SCREEN_WIDTH / BLOCK_WIDTH;
  localparam int ROWS    = SCREEN_HEIGHT / BLOCK_HEIGHT;
  localparam int N_SLOTS = COLS * ROWS;
  localparam int AW      = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int CW      = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic        active;
  } block_entry_t;

endpackage

// File: rtl/collision_scan_controller_if.sv
// -----------------------------------------------------------------------------
// collision_scan_controller_if
// Purpose : bundles the scan request/result handshake and the block-table read
//           port of the collision scan controller.
// Signals :
//   start, doodle_x, doodle_y, doodle_falling   request from the game-tick FSM
//   busy, done, hit, hit_col, hit_row           result back to the game-tick FSM
//   blk_rd_en, blk_rd_addr                      read request to the block table
//   blk_rd_x, blk_rd_y, blk_rd_active           read data (1 cycle after rd_en)
// Modports:
//   slave  - the scan controller
//   master - its environment (tick FSM + block-table RAM)
// -----------------------------------------------------------------------------
interface collision_scan_controller_if;
  import collision_pkg::*;

  logic          start;
  logic [31:0]   doodle_x;
  logic [31:0]   doodle_y;
  logic          doodle_falling;

  logic          blk_rd_en;
  logic [AW-1:0] blk_rd_addr;
  logic [31:0]   blk_rd_x;
  logic [31:0]   blk_rd_y;
  logic          blk_rd_active;

  logic          busy;
  logic          done;
  logic          hit;
  logic [31:0]   hit_col;
  logic [31:0]   hit_row;

  modport slave (
    input  start, doodle_x, doodle_y, doodle_falling,
    input  blk_rd_x, blk_rd_y, blk_rd_active,
    output blk_rd_en, blk_rd_addr,
    output busy, done, hit, hit_col, hit_row
  );

  modport master (
    output start, doodle_x, doodle_y, doodle_falling,
    output blk_rd_x, blk_rd_y, blk_rd_active,
    input  blk_rd_en, blk_rd_addr,
    input  busy, done, hit, hit_col, hit_row
  );

endinterface

// File: rtl/collision_scan_controller_compare.sv
// -----------------------------------------------------------------------------
// collision_compare
// Purpose : single-slot combinational landing test.
// Ports   :
//   i_blk      block-table entry {x, y, active}
//   i_x, i_y   doodle snapshot position (y = feet)
//   i_falling  doodle snapshot falling flag
//   o_hit      slot collides with the doodle
// Optional: COLLISION_Y_TOLERANCE_EN widens the Y test from exact equality to
//           blk.y <= y <= blk.y + Y_TOL.
// All arithmetic is unsigned; upper bounds are formed at 33 bits so a block
// placed near 2^32 cannot wrap its window back to small values.
// -----------------------------------------------------------------------------
module collision_compare
  import collision_pkg::*;
(
  input  block_entry_t i_blk,
  input  logic [31:0]  i_x,
  input  logic [31:0]  i_y,
  input  logic         i_falling,
  output logic         o_hit
);

  logic [32:0] w_x_hi;
  logic        w_x_ok;
  logic        w_y_ok;

  assign w_x_hi = {1'b0, i_blk.x} + 33'(BLOCK_WIDTH);
  assign w_x_ok = (i_x >= i_blk.x) && ({1'b0, i_x} <= w_x_hi);

`ifdef COLLISION_Y_TOLERANCE_EN
  logic [32:0] w_y_hi;
  assign w_y_hi = {1'b0, i_blk.y} + 33'(Y_TOL);
  assign w_y_ok = (i_y >= i_blk.y) && ({1'b0, i_y} <= w_y_hi);
`else
  assign w_y_ok = (i_y == i_blk.y);
`endif

  assign o_hit = i_blk.active && i_falling && w_y_ok && w_x_ok;

endmodule

// File: rtl/collision_scan_controller.sv
// -----------------------------------------------------------------------------
// collision_scan_controller
// Purpose : walks every block-table slot once per start, row-major, one read
//           per cycle, and reports the first slot the doodle lands on.
// Ports   :
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  collision_scan_controller_if.slave (handshake + block-table port)
// Timing  : start accepted in cycle 0 -> read of slot k on the bus in cycle
//           k+1 -> its data compared in cycle k+2 -> done in cycle k+3.
//           No hit: done in cycle N_SLOTS+2.
// Optional: COLLISION_Y_TOLERANCE_EN (handled inside collision_compare).
// -----------------------------------------------------------------------------
module collision_scan_controller
  import collision_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  collision_scan_controller_if.slave    bus
);

  state_t        r_state;
  logic          r_busy;
  logic          r_done;
  logic          r_hit;
  logic [31:0]   r_hit_col;
  logic [31:0]   r_hit_row;
  logic          r_rd_en;
  logic [AW-1:0] r_rd_addr;
  // r_cmp_valid marks that read data for the slot at (r_cmp_row, r_cmp_col)
  // is on the block-table bus this cycle.
  logic          r_cmp_valid;
  logic [CW-1:0] r_cmp_col;
  logic [RW-1:0] r_cmp_row;
  logic [31:0]   r_snap_x;
  logic [31:0]   r_snap_y;
  logic          r_snap_falling;

  block_entry_t  w_entry;
  logic          w_slot_hit;
  logic          w_last_issue;
  logic          w_last_cmp;

  assign w_entry.x      = bus.blk_rd_x;
  assign w_entry.y      = bus.blk_rd_y;
  assign w_entry.active = bus.blk_rd_active;

  collision_compare u_compare (
    .i_blk     (w_entry),
    .i_x       (r_snap_x),
    .i_y       (r_snap_y),
    .i_falling (r_snap_falling),
    .o_hit     (w_slot_hit)
  );

  assign w_last_issue = (r_rd_addr == AW'(N_SLOTS - 1));
  assign w_last_cmp   = (r_cmp_col == CW'(COLS - 1)) && (r_cmp_row == RW'(ROWS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_hit          <= 1'b0;
      r_hit_col      <= '0;
      r_hit_row      <= '0;
      r_rd_en        <= 1'b0;
      r_rd_addr      <= '0;
      r_cmp_valid    <= 1'b0;
      r_cmp_col      <= '0;
      r_cmp_row      <= '0;
      r_snap_x       <= '0;
      r_snap_y       <= '0;
      r_snap_falling <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_snap_x       <= bus.doodle_x;
            r_snap_y       <= bus.doodle_y;
            r_snap_falling <= bus.doodle_falling;
            r_hit          <= 1'b0;
            r_hit_col      <= '0;
            r_hit_row      <= '0;
            r_busy         <= 1'b1;
            r_rd_en        <= 1'b1;
            r_rd_addr      <= '0;
            r_cmp_valid    <= 1'b0;
            r_cmp_col      <= '0;
            r_cmp_row      <= '0;
            r_state        <= SCAN;
          end
        end

        SCAN: begin
          // Issue side: one address per cycle, stopping after the last slot.
          r_cmp_valid <= r_rd_en;
          if (r_rd_en) begin
            if (w_last_issue) begin
              r_rd_en <= 1'b0;
            end else begin
              r_rd_addr <= r_rd_addr + AW'(1);
            end
          end
          // Compare side: one slot behind the issue side. These assignments
          // override the issue side so a hit stops further reads at once.
          if (r_cmp_valid) begin
            if (w_slot_hit) begin
              r_hit       <= 1'b1;
              r_hit_col   <= 32'(r_cmp_col);
              r_hit_row   <= 32'(r_cmp_row);
              r_rd_en     <= 1'b0;
              r_cmp_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= FINISH;
            end else if (w_last_cmp) begin
              r_cmp_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= FINISH;
            end else if (r_cmp_col == CW'(COLS - 1)) begin
              r_cmp_col <= '0;
              r_cmp_row <= r_cmp_row + RW'(1);
            end else begin
              r_cmp_col <= r_cmp_col + CW'(1);
            end
          end
        end

        FINISH: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.blk_rd_en   = r_rd_en;
  assign bus.blk_rd_addr = r_rd_addr;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.hit         = r_hit;
  assign bus.hit_col     = r_hit_col;
  assign bus.hit_row     = r_hit_row;

endmodule

// File: tb/tb_collision_scan_controller.sv
// -----------------------------------------------------------------------------
// tb_collision_scan_controller
// Directed scans against a behavioural block-table RAM. Each scan pushes its
// expected result (hit, col, row, start->done latency, busy cycles, highest
// address read) into a queue; a negedge monitor pops and compares on done.
// -----------------------------------------------------------------------------
module tb_collision_scan_controller;
  import collision_pkg::*;

  typedef struct {
    string  name;
    logic   hit;
    integer col;
    integer row;
    integer lat;
    integer busy_cyc;
    integer max_addr;
    integer start_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  collision_scan_controller_if bus ();

  collision_scan_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  block_entry_t mem [N_SLOTS];
  exp_t   sb_q [$];
  exp_t   e;
  integer n_cmp = 0;
  integer n_err = 0;
  integer cyc = 0;
  integer mon_busy = 0;
  integer mon_max_addr = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Block-table RAM with registered read.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.blk_rd_x      <= '0;
      bus.blk_rd_y      <= '0;
      bus.blk_rd_active <= 1'b0;
    end else if (bus.blk_rd_en && (int'(bus.blk_rd_addr) < N_SLOTS)) begin
      bus.blk_rd_x      <= mem[bus.blk_rd_addr].x;
      bus.blk_rd_y      <= mem[bus.blk_rd_addr].y;
      bus.blk_rd_active <= mem[bus.blk_rd_addr].active;
    end
  end

  function automatic void chk(string nm, integer act, integer expv);
    n_cmp = n_cmp + 1;
    if (act !== expv) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endfunction

  // Monitor / scoreboard checker.
  always @(negedge clk) begin
    if (rst) begin
      mon_busy     = 0;
      mon_max_addr = -1;
    end else begin
      if (bus.busy) mon_busy = mon_busy + 1;
      if (bus.blk_rd_en && (int'(bus.blk_rd_addr) > mon_max_addr))
        mon_max_addr = int'(bus.blk_rd_addr);
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          n_cmp = n_cmp + 1;
          n_err = n_err + 1;
          $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
        end else begin
          e = sb_q.pop_front();
          chk({e.name, ".hit"},      bus.hit, e.hit);
          chk({e.name, ".hit_col"},  bus.hit_col, e.col);
          chk({e.name, ".hit_row"},  bus.hit_row, e.row);
          chk({e.name, ".latency"},  cyc - e.start_cyc, e.lat);
          chk({e.name, ".busy_cyc"}, mon_busy, e.busy_cyc);
          chk({e.name, ".max_addr"}, mon_max_addr, e.max_addr);
          $display("scan %-12s hit=%0d col=%0d row=%0d lat=%0d busy=%0d max_addr=%0d",
                   e.name, bus.hit, bus.hit_col, bus.hit_row, cyc - e.start_cyc,
                   mon_busy, mon_max_addr);
        end
        mon_busy     = 0;
        mon_max_addr = -1;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < N_SLOTS; i++) mem[i] = '0;
  endtask

  task automatic set_blk(input int k, input int x, input int y);
    mem[k].x      = 32'(x);
    mem[k].y      = 32'(y);
    mem[k].active = 1'b1;
  endtask

  task automatic pulse_start(input int dx, input int dy, input bit f);
    @(negedge clk);
    bus.doodle_x       = 32'(dx);
    bus.doodle_y       = 32'(dy);
    bus.doodle_falling = f;
    bus.start          = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // ek: expected hit slot (ignored when eh = 0). disturb: re-pulse start and
  // scramble the doodle inputs mid-scan.
  task automatic scan(input string nm, input int dx, input int dy, input bit f,
                      input bit eh, input int ek, input bit disturb);
    exp_t x;
    int   k;
    k           = eh ? ek : N_SLOTS - 1;
    x.name      = nm;
    x.hit       = eh;
    x.col       = eh ? ek % COLS : 0;
    x.row       = eh ? ek / COLS : 0;
    x.lat       = k + 3;
    x.busy_cyc  = k + 2;
    x.max_addr  = (k + 1 > N_SLOTS - 1) ? N_SLOTS - 1 : k + 1;
    @(negedge clk);
    x.start_cyc = cyc;
    sb_q.push_back(x);
    bus.doodle_x       = 32'(dx);
    bus.doodle_y       = 32'(dy);
    bus.doodle_falling = f;
    bus.start          = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (disturb) begin
      repeat (5) @(negedge clk);
      bus.start          = 1'b1;
      bus.doodle_x       = 32'd0;
      bus.doodle_y       = 32'd0;
      bus.doodle_falling = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
    end
    for (int i = 0; i < N_SLOTS + 50; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    if (sb_q.size() != 0) begin
      n_cmp = n_cmp + 1;
      n_err = n_err + 1;
      $display("FAIL %s.timeout: got no done, expected done within %0d cycles", nm, N_SLOTS + 50);
      sb_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bus.start          = 1'b0;
    bus.doodle_x       = '0;
    bus.doodle_y       = '0;
    bus.doodle_falling = 1'b0;
    rst = 1'b1;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("reset.busy",    bus.busy, 0);
    chk("reset.done",    bus.done, 0);
    chk("reset.hit",     bus.hit, 0);
    chk("reset.rd_en",   bus.blk_rd_en, 0);
    chk("reset.rd_addr", bus.blk_rd_addr, 0);
    chk("reset.hit_col", bus.hit_col, 0);
    chk("reset.hit_row", bus.hit_row, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single active block at slot 23 (row 2, col 3).
    set_blk(23, 128, 200);
    scan("slot23",     150, 200, 1'b1, 1'b1, 23, 1'b0);
    scan("x127_miss",  127, 200, 1'b1, 1'b0, 0,  1'b0);
    scan("x193_miss",  193, 200, 1'b1, 1'b0, 0,  1'b0);
    scan("x128_hit",   128, 200, 1'b1, 1'b1, 23, 1'b0);
    scan("x192_hit",   192, 200, 1'b1, 1'b1, 23, 1'b0);
    scan("not_fall",   150, 200, 1'b0, 1'b0, 0,  1'b0);
    scan("disturbed",  150, 200, 1'b1, 1'b1, 23, 1'b1);

`ifdef COLLISION_Y_TOLERANCE_EN
    scan("y203",       150, 203, 1'b1, 1'b1, 23, 1'b0);
`else
    scan("y203",       150, 203, 1'b1, 1'b0, 0,  1'b0);
`endif
    scan("y205",       150, 205, 1'b1, 1'b0, 0,  1'b0);
    scan("y199",       150, 199, 1'b1, 1'b0, 0,  1'b0);

    // Two matching slots: the earlier one (slot 5) wins.
    clear_mem();
    set_blk(5, 128, 200);
    set_blk(40, 128, 200);
    scan("first_wins", 150, 200, 1'b1, 1'b1, 5, 1'b0);

    // Nothing active.
    clear_mem();
    scan("all_off",    150, 200, 1'b1, 1'b0, 0, 1'b0);

    // Reset in the middle of a scan that would otherwise hit.
    set_blk(23, 128, 200);
    scan("pre_rst",    150, 200, 1'b1, 1'b1, 23, 1'b0);
    pulse_start(150, 200, 1'b1);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst.busy",  bus.busy, 0);
    chk("midrst.rd_en", bus.blk_rd_en, 0);
    chk("midrst.hit",   bus.hit, 0);
    chk("midrst.done",  bus.done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    scan("post_rst",   150, 200, 1'b1, 1'b1, 23, 1'b0);

    if (sb_q.size() != 0) begin
      n_cmp = n_cmp + 1;
      n_err = n_err + 1;
      $display("FAIL leftover: got %0d pending results, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
